fb_host_write_port: RTL and testbench
=====================================

// Module: fb_host_write_port
// PURPOSE
//  Upstream feeder of the VGA scan-out framebuffer (200x150, 3-bit RGB).
//  Synchronises the host's asynchronous write strobe into the pixel clock domain and captures address/RGB.
//  Range-checks and buffers each write in a small FIFO, then presents it on a valid/ready write port.
//  Also performs a full-framebuffer clear to a fixed colour on request.
// PARAMETERS
//  FB_DEPTH     30000   number of valid pixel addresses (0..FB_DEPTH-1)
//  FIFO_DEPTH   4       pending-write buffer entries, power of 2, >=2
//  CLEAR_COLOR  3'b000  RGB written by clear sequence, bit0=R bit1=G bit2=B
// PORTS
//  CLK         in   1   10 MHz pixel clock (same as scan-out)
//  RESET_N     in   1   async assert, active-low reset
//  STROBE      in   1   host write strobe, asynchronous; rising edge = one write
//  ADDR_IN     in   15  host pixel address = x + y*200; stable while STROBE high
//  RGB_IN      in   3   host pixel colour; stable while STROBE high
//  CLEAR_REQ   in   1   CLK-domain pulse: start full clear
//  WR_EN       out  1   write valid to framebuffer
//  WR_ADDR     out  15  write address
//  WR_DATA     out  3   write colour
//  WR_READY    in   1   framebuffer accepts write this cycle (handshake = WR_EN & WR_READY)
//  BUSY        out  1   clear in progress or FIFO non-empty
//  OVERFLOW    out  1   sticky: a host write was lost to a full FIFO
//  DROP_COUNT  out  8   saturating count of out-of-range host addresses
// BEHAVIOUR
//  Reset (async, RESET_N=0): FIFO empty, state IDLE, all outputs 0, DROP_COUNT=0, OVERFLOW=0;
//   sync flops s1/s2/s3 reset to 1 so a STROBE held high through reset is NOT taken as a write.
//  Sync: s1<=STROBE, s2<=s1, s3<=s2; edge = s2 & ~s3. ADDR_IN/RGB_IN sampled in the edge cycle
//   (host contract: STROBE high >= 3 CLK, data stable from before rise until fall).
//  Edge cycle: addr >= FB_DEPTH -> discard, DROP_COUNT+1 (saturate 255); else push {addr,rgb}.
//  Push while full and no pop same cycle -> entry discarded, OVERFLOW<=1 (cleared only by reset).
//  Push and pop in same cycle when full -> both occur, no overflow.
//  Latency: STROBE rise -> WR_EN high within 3 CLK edges when FIFO empty and state IDLE.
//  States:
//   IDLE : WR_EN = FIFO non-empty; WR_ADDR/WR_DATA = FIFO head; pop on WR_EN&WR_READY.
//          CLEAR_REQ -> CLEAR, clr_cnt<=0 (takes priority over FIFO; pending entries wait).
//   CLEAR: WR_EN=1, WR_ADDR=clr_cnt, WR_DATA=CLEAR_COLOR; on WR_READY clr_cnt+1;
//          accepted write at FB_DEPTH-1 -> IDLE. CLEAR_REQ ignored. Host pushes continue
//          into FIFO and drain after clear, so post-clear host pixels survive.
//  WR_EN held with stable WR_ADDR/WR_DATA until WR_READY; never drops valid without handshake.
//  WR_ADDR/WR_DATA are 0 when WR_EN=0 (no X on output).
//  BUSY = (state==CLEAR) | FIFO non-empty, registered-consistent with WR_EN.
//  Counters: FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; clr_cnt 15 bits, never exceeds FB_DEPTH-1.
// STRUCTURE
//  fb_pkg: FB_WIDTH=200, FB_HEIGHT=150, FB_DEPTH=30000, FB_ADDR_W=15, FB_RGB_W=3,
//   pixel-write struct {addr,rgb}, state encoding IDLE/CLEAR.
//  Sub-module fb_wr_fifo: sync FIFO (push/pop/full/empty, head data), parameterised depth/width.
//  Top: synchroniser + edge detect, range check/counters, clear FSM, output mux.
// TESTING
//  1 STROBE 4-CLK pulse, ADDR=123, RGB=3'b101, WR_READY=1 -> one WR_EN cycle, 123/101, within 3 CLK.
//  2 ADDR=30000 and 32767 strobes -> no WR_EN, DROP_COUNT=2; 300 such strobes -> DROP_COUNT=255.
//  3 WR_READY=0, 6 strobes addr 0..5 -> FIFO holds 0..3, OVERFLOW=1; release -> writes 0,1,2,3 in order.
//  4 CLEAR_REQ, WR_READY=1 -> 30000 writes addr 0..29999 data CLEAR_COLOR, then IDLE, BUSY low.
//  5 Strobe addr 77 mid-clear -> write 77 appears after addr 29999; second CLEAR_REQ mid-clear ignored.
//  6 RESET_N low mid-clear with FIFO occupied, STROBE held high -> outputs 0; no write after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, the pixel-write record and the write-port state encoding.
// Imported by the host write port and its pending-write FIFO.
package fb_pkg;

    localparam int FB_WIDTH  = 200;
    localparam int FB_HEIGHT = 150;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 15;
    localparam int FB_RGB_W  = 3;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_RGB_W-1:0]  rgb;
    } pix_wr_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wr_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO for pending pixel writes; head data is visible combinationally, push/pop same cycle.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_dat_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/fb_host_write_port.sv
// Host-to-framebuffer write port: syncs the async strobe, range-checks, buffers and emits writes or a full clear.
// Strobe rise to WR_EN in 3 CLK edges when idle; WR_EN/WR_ADDR/WR_DATA hold until WR_READY.
module fb_host_write_port #(
    parameter int unsigned FB_DEPTH    = 30000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STROBE,
    input  logic [14:0] ADDR_IN,
    input  logic [2:0]  RGB_IN,
    input  logic        CLEAR_REQ,
    output logic        WR_EN,
    output logic [14:0] WR_ADDR,
    output logic [2:0]  WR_DATA,
    input  logic        WR_READY,
    output logic        BUSY,
    output logic        OVERFLOW,
    output logic [7:0]  DROP_COUNT
);

    import fb_pkg::*;

    localparam logic [14:0] LAST_ADDR = 15'(FB_DEPTH - 1);

    logic        s1_q, s2_q, s3_q;
    logic        strobe_rise, addr_ok;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    pix_wr_t     push_dat, head_dat;
    wr_state_e   state_q;
    logic [14:0] clr_cnt_q;
    logic        overflow_q;
    logic [7:0]  drop_cnt_q;

    // Flops reset high so a strobe already high when reset releases is not seen as a rising edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= STROBE;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign strobe_rise = s2_q & ~s3_q;
    assign addr_ok     = (32'(ADDR_IN) < FB_DEPTH);
    assign push_dat    = '{addr: ADDR_IN, rgb: RGB_IN};
    assign fifo_push   = strobe_rise & addr_ok;
    assign fifo_pop    = (state_q == ST_IDLE) & ~fifo_empty & WR_READY;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_wr_t))
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .push_i     (fifo_push),
        .push_dat_i (push_dat),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (head_dat)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            if (fifo_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
            if (strobe_rise && !addr_ok)             drop_cnt_q <= sat_inc8(drop_cnt_q);
        end
    end

    // A clear request wins over queued host writes, which stay buffered until the clear completes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CLEAR_REQ) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (WR_READY) begin
                        if (clr_cnt_q == LAST_ADDR) begin
                            state_q   <= ST_IDLE;
                            clr_cnt_q <= '0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 15'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        WR_EN   = 1'b0;
        WR_ADDR = '0;
        WR_DATA = '0;
        if (state_q == ST_CLEAR) begin
            WR_EN   = 1'b1;
            WR_ADDR = clr_cnt_q;
            WR_DATA = CLEAR_COLOR;
        end else if (!fifo_empty) begin
            WR_EN   = 1'b1;
            WR_ADDR = head_dat.addr;
            WR_DATA = head_dat.rgb;
        end
    end

    assign BUSY       = (state_q == ST_CLEAR) | ~fifo_empty;
    assign OVERFLOW   = overflow_q;
    assign DROP_COUNT = drop_cnt_q;

endmodule

// File: tb/tb_fb_host_write_port.sv
// Directed + randomized bench for fb_host_write_port; expected writes come from a queue model of host intent.
module tb_fb_host_write_port;

    localparam logic [2:0] CLR_RGB = 3'b000;
    localparam int         NPIX    = 30000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strobe;
    logic [14:0] addr_in;
    logic [2:0]  rgb_in;
    logic        clear_req;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    fb_host_write_port dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .STROBE     (strobe),
        .ADDR_IN    (addr_in),
        .RGB_IN     (rgb_in),
        .CLEAR_REQ  (clear_req),
        .WR_EN      (wr_en),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .WR_READY   (wr_ready),
        .BUSY       (busy),
        .OVERFLOW   (overflow),
        .DROP_COUNT (drop_count)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit rnd_rdy = 1'b0;

    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    int          zero_viol = 0;
    int          hold_viol = 0;
    logic        prev_pend = 1'b0;
    logic [17:0] prev_dat  = '0;

    // Observes accepted writes and the output-hold rules on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (wr_en && wr_ready) got_q.push_back({wr_addr, wr_data});
            if (!wr_en && (wr_addr != 15'd0 || wr_data != 3'd0)) zero_viol++;
            if (prev_pend && (!wr_en || {wr_addr, wr_data} != prev_dat)) hold_viol++;
            prev_pend = wr_en && !wr_ready;
            prev_dat  = {wr_addr, wr_data};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) wr_ready = ($urandom_range(0, 7) != 0);
    endtask

    task automatic strobe_wr(input logic [14:0] a, input logic [2:0] c, input int hi);
        addr_in = a;
        rgb_in  = c;
        #($urandom_range(0, 40));
        strobe = 1'b1;
        repeat (hi) step();
        strobe = 1'b0;
        step();
        step();
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_clear_run(input int start, input string tag);
        int bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (start + i >= got_q.size()) bad++;
            else if (got_q[start + i] !== {15'(i), CLR_RGB}) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int          lat;
        int          n_oor;
        int          guard;
        logic [2:0]  c77;
        logic [2:0]  rgbs [6];
        logic [14:0] a;
        logic [2:0]  c;

        rst_n = 1'b0; strobe = 1'b0; addr_in = '0; rgb_in = '0; clear_req = 1'b0; wr_ready = 1'b1;
        repeat (3) step();
        check("reset_outputs", 32'({wr_en, wr_addr, wr_data, busy, overflow, drop_count}), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single write and strobe-to-valid latency.
        addr_in = 15'd123; rgb_in = 3'b101;
        #($urandom_range(0, 40));
        strobe = 1'b1;
        lat = 0;
        while (!wr_en && lat < 6) begin
            step();
            lat++;
        end
        check("t1_latency_le3", 32'(lat <= 3 && wr_en), 32'd1);
        check("t1_wr_fields", 32'({wr_addr, wr_data}), 32'({15'd123, 3'b101}));
        while (lat < 4) begin
            step();
            lat++;
        end
        strobe = 1'b0;
        repeat (4) step();
        check("t1_one_write", 32'(got_q.size()), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);

        // Out-of-range addresses are dropped and counted with saturation.
        got_q.delete();
        strobe_wr(15'd30000, 3'd7, 3);
        strobe_wr(15'd32767, 3'd2, 3);
        repeat (3) step();
        check("t2_no_write", 32'(got_q.size()), 32'd0);
        check("t2_drop2", 32'(drop_count), 32'd2);
        n_oor = 2;
        repeat (253) begin
            strobe_wr(15'($urandom_range(NPIX, 32767)), 3'($urandom_range(0, 7)), 3);
            n_oor++;
        end
        check("t2_drop255", 32'(drop_count), 32'((n_oor > 255) ? 255 : n_oor));
        repeat (45) strobe_wr(15'($urandom_range(NPIX, 32767)), 3'd1, 3);
        check("t2_drop_sat", 32'(drop_count), 32'd255);

        // Stalled sink: four entries buffered, the rest lost and flagged.
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rgbs[i] = 3'($urandom_range(0, 7));
            strobe_wr(15'(i), rgbs[i], 3);
            if (i == 3) check("t3_no_ovf_at_4", 32'(overflow), 32'd0);
        end
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_head_held", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 15'd0, rgbs[0]}));
        wr_ready = 1'b1;
        wait_idle(20, "t3_drain_timeout");
        check("t3_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_order%0d", i), 32'((i < got_q.size()) ? got_q[i] : 18'h3ffff),
                  32'({15'(i), rgbs[i]}));

        // Full clear with an always-ready sink.
        got_q.delete();
        pulse_clear();
        check("t4_busy_in_clear", 32'(busy), 32'd1);
        wait_idle(NPIX + 100, "t4_clear_timeout");
        check("t4_count", 32'(got_q.size()), 32'(NPIX));
        check_clear_run(0, "t4_clear_seq");
        check("t4_idle_outputs", 32'({wr_en, wr_addr, wr_data}), 32'd0);

        // Clear with a jittery sink, a host write and a repeated request mid-clear.
        got_q.delete();
        rnd_rdy = 1'b1;
        pulse_clear();
        repeat (100) step();
        c77 = 3'($urandom_range(0, 7));
        strobe_wr(15'd77, c77, 4);
        repeat (100) step();
        pulse_clear();
        wait_idle(NPIX * 2, "t5_clear_timeout");
        check("t5_count", 32'(got_q.size()), 32'(NPIX + 1));
        check_clear_run(0, "t5_clear_seq");
        check("t5_host_after_clear", 32'((got_q.size() > 0) ? got_q[got_q.size() - 1] : 18'h3ffff),
              32'({15'd77, c77}));
        rnd_rdy  = 1'b0;
        wr_ready = 1'b1;

        // Reset mid-clear with a queued entry and strobe held high.
        pulse_clear();
        repeat (50) step();
        wr_ready = 1'b0;
        addr_in = 15'd9; rgb_in = 3'd6;
        strobe = 1'b1;
        repeat (5) step();
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        #20;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", 32'({wr_en, wr_addr, wr_data, busy, overflow, drop_count}), 32'd0);
        got_q.delete();
        repeat (3) step();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (10) step();
        check("t6_no_write_after_rst", 32'(got_q.size()), 32'd0);
        check("t6_idle_after_rst", 32'({busy, wr_en}), 32'd0);
        strobe = 1'b0;
        repeat (3) step();

        // Randomized traffic against the queue model.
        rnd_rdy = 1'b1;
        n_oor = 0;
        for (int k = 0; k < 40; k++) begin
            guard = 0;
            while (exp_q.size() - got_q.size() >= 2 && guard < 200) begin
                step();
                guard++;
            end
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                a = 15'($urandom_range(NPIX, 32767));
                n_oor++;
            end else begin
                a = 15'($urandom_range(0, NPIX - 1));
                exp_q.push_back({a, c});
            end
            strobe_wr(a, c, $urandom_range(3, 5));
        end
        wait_idle(200, "rnd_drain_timeout");
        check("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rnd_wr%0d", i), 32'((i < got_q.size()) ? got_q[i] : 18'h3ffff), 32'(exp_q[i]));
        check("rnd_drop", 32'(drop_count), 32'((n_oor > 255) ? 255 : n_oor));
        check("rnd_no_overflow", 32'(overflow), 32'd0);
        check("zero_when_idle", 32'(zero_viol), 32'd0);
        check("hold_until_ready", 32'(hold_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
